// File: rtl/l1d_writeback_unit.sv
// ---------------------------------------------------------------------------
// l1d_writeback_unit
//
// Eviction read side of the L1 D-cache data array. A victim (index, way, tag)
// is accepted from the cache controller. In the same cycle the victim line is
// snapshotted from the data array's combinational read port. The unit then
// issues one address request and streams the line to the next level as
// BEAT_W-wide beats, least-significant beat first. It stays busy until the
// memory side pulses mem_ack. Only one eviction is in flight at a time.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   evict_valid/ready victim handshake; ready only while idle
//   evict_index/way/tag victim identity
//   da_index          read index to the data array (evict_index while idle,
//                     held at the captured index otherwise)
//   da_lines          all ways of the line at da_index (combinational read)
//   mem_req_*         writeback address request, addr = {tag, index, 0}
//   mem_data_*        line data beats, mem_data_last marks the final beat
//   mem_ack           single-cycle write-complete pulse from memory
//   busy              unit holds an eviction (state != IDLE)
// ---------------------------------------------------------------------------
module l1d_writeback_unit #(
    parameter  int LINE_W    = 512,
    parameter  int NUM_SETS  = 64,
    parameter  int NUM_WAYS  = 4,
    parameter  int BEAT_W    = 64,
    parameter  int ADDR_W    = 32,
    localparam int IDX_W     = $clog2(NUM_SETS),
    localparam int WAY_W     = $clog2(NUM_WAYS),
    localparam int OFF_W     = $clog2(LINE_W / 8),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic                             evict_valid,
    output logic                             evict_ready,
    input  logic [IDX_W-1:0]                 evict_index,
    input  logic [WAY_W-1:0]                 evict_way,
    input  logic [TAG_W-1:0]                 evict_tag,

    output logic [IDX_W-1:0]                 da_index,
    input  logic [NUM_WAYS-1:0][LINE_W-1:0]  da_lines,

    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_W-1:0]                mem_req_addr,

    output logic                             mem_data_valid,
    input  logic                             mem_data_ready,
    output logic [BEAT_W-1:0]                mem_data,
    output logic                             mem_data_last,

    input  logic                             mem_ack,
    output logic                             busy
);

    localparam int NUM_BEATS = LINE_W / BEAT_W;
    localparam int CNT_W     = $clog2(NUM_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_ACK
    } state_e;

    // Line viewed as beats so beat k is simply element k (beat 0 = LSBs).
    typedef logic [NUM_BEATS-1:0][BEAT_W-1:0] line_t;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    line_t                    line_buf_q, line_buf_d;
    logic [TAG_W+IDX_W-1:0]   addr_q, addr_d;      // {tag, index}

    logic                     last_beat;
    logic [IDX_W-1:0]         index_q;

    assign last_beat = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
    assign index_q   = addr_q[IDX_W-1:0];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; combinational blocks below use blocking (=).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every comb output gets a default before the case, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (evict_valid)                    state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)                  state_d = ST_DATA;
            ST_DATA: if (mem_data_ready && last_beat)    state_d = ST_ACK;
            ST_ACK:  if (mem_ack)                        state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        evict_ready    = 1'b0;
        busy           = 1'b1;
        mem_req_valid  = 1'b0;
        mem_data_valid = 1'b0;
        mem_data_last  = 1'b0;
        da_index       = index_q;
        unique case (state_q)
            ST_IDLE: begin
                evict_ready = 1'b1;
                busy        = 1'b0;
                // Same-cycle array read so the line is captured on accept.
                da_index    = evict_index;
            end
            ST_REQ:  mem_req_valid = 1'b1;
            ST_DATA: begin
                mem_data_valid = 1'b1;
                mem_data_last  = last_beat;
            end
            ST_ACK:  ;
            default: ;
        endcase
    end

    assign mem_req_addr = {addr_q, {OFF_W{1'b0}}};
    assign mem_data     = line_buf_q[beat_cnt_q];

    // -----------------------------------------------------------------------
    // Datapath: line snapshot, address capture, beat counter
    // -----------------------------------------------------------------------
    always_comb begin
        line_buf_d = line_buf_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;

        // The array read port is sampled at the accepting edge, so a write
        // to the same line on that edge is not seen: the old line is evicted.
        if (evict_valid && evict_ready) begin
            line_buf_d = da_lines[evict_way];
            addr_d     = {evict_tag, evict_index};
        end

        // The counter stops on the last beat rather than wrapping; DATA is
        // left on that handshake anyway.
        if (state_q == ST_REQ && mem_req_ready) begin
            beat_cnt_d = '0;
        end else if (state_q == ST_DATA && mem_data_ready && !last_beat) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: line_buf is a flop array, not a RAM macro, so it can be reset;
    // clearing it keeps mem_data at zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            line_buf_q <= '0;
            addr_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_buf_q <= line_buf_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_l1d_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_l1d_writeback_unit
//
// Self-checking bench for l1d_writeback_unit. A behavioural data array
// supplies lines. A table of eviction records drives the unit; the expected
// beats are queued when a victim is accepted and are compared on each cycle
// the unit presents a beat. A beat is popped on its handshake.
// ---------------------------------------------------------------------------
module tb_l1d_writeback_unit;

    localparam int LINE_W    = 512;
    localparam int NUM_SETS  = 64;
    localparam int NUM_WAYS  = 4;
    localparam int BEAT_W    = 64;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = 6;
    localparam int WAY_W     = 2;
    localparam int TAG_W     = 20;
    localparam int NUM_BEATS = LINE_W / BEAT_W;
    localparam int FLIP_IDX  = 0;
    localparam int FLIP_WAY  = 0;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            evict_valid;
    logic                            evict_ready;
    logic [IDX_W-1:0]                evict_index;
    logic [WAY_W-1:0]                evict_way;
    logic [TAG_W-1:0]                evict_tag;
    logic [IDX_W-1:0]                da_index;
    logic [NUM_WAYS-1:0][LINE_W-1:0] da_lines;
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic [ADDR_W-1:0]               mem_req_addr;
    logic                            mem_data_valid;
    logic                            mem_data_ready;
    logic [BEAT_W-1:0]               mem_data;
    logic                            mem_data_last;
    logic                            mem_ack;
    logic                            busy;

    always #5 clk = ~clk;

    l1d_writeback_unit #(
        .LINE_W   (LINE_W),
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .BEAT_W   (BEAT_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evict_valid    (evict_valid),
        .evict_ready    (evict_ready),
        .evict_index    (evict_index),
        .evict_way      (evict_way),
        .evict_tag      (evict_tag),
        .da_index       (da_index),
        .da_lines       (da_lines),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .mem_data_last  (mem_data_last),
        .mem_ack        (mem_ack),
        .busy           (busy)
    );

    // ---------------------------------------------------------------- array
    // Set 5 / way 2 holds 64'h1111*k in beat k; other lines hold a tagged
    // pattern. One line (FLIP_IDX/FLIP_WAY) is inverted by a write landing on
    // the same edge that accepts it as a victim.
    function automatic logic [BEAT_W-1:0] fill_word(int s, int w, int k);
        if (s == 5 && w == 2) return 64'h1111 * k;
        return {8'hA5, 8'(s), 8'(w), 8'(k), 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [LINE_W-1:0] line_of(int s, int w, bit flipped);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < NUM_BEATS; k++) l[k*BEAT_W +: BEAT_W] = fill_word(s, w, k);
        return flipped ? ~l : l;
    endfunction

    bit flip_req;
    bit flip_q;

    always_ff @(posedge clk) flip_q <= flip_q | flip_req;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++)
            da_lines[w] = line_of(int'(da_index), w,
                                  flip_q && int'(da_index) == FLIP_IDX && w == FLIP_WAY);
    end

    // ---------------------------------------------------------------- checks
    int n_pass   = 0;
    int n_total  = 0;
    int busy_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cyc++;
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [BEAT_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];

    // ------------------------------------------------------------- vectors
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [WAY_W-1:0]  way;
        logic [TAG_W-1:0]  tag;
        int                req_stall;   // cycles mem_req_ready held low
        bit                toggle;      // mem_data_ready 1/0/1/0...
        int                ack_delay;   // ACK cycles before mem_ack
        bit                stray_ack;   // pulse mem_ack while in REQ
        bit                hold_valid;  // keep evict_valid high while busy
        bit                collide;     // array write on the accepting edge
        logic [ADDR_W-1:0] exp_addr;
        int                exp_busy;    // cycles with busy=1
    } vec_t;

    vec_t vecs[5];

    task automatic run_evict(input vec_t v);
        logic [LINE_W-1:0] line;
        beat_t             b;
        int                beats;
        int                dcyc;

        busy_cyc = 0;
        check("idle_ready", evict_ready, 1);
        check("idle_busy", busy, 0);
        evict_index = v.idx;
        evict_way   = v.way;
        evict_tag   = v.tag;
        evict_valid = 1'b1;
        flip_req    = v.collide;
        #1 check("da_index_idle", da_index, v.idx);

        line = line_of(int'(v.idx), int'(v.way), 1'b0);
        for (int k = 0; k < NUM_BEATS; k++) begin
            b.data = line[k*BEAT_W +: BEAT_W];
            b.last = (k == NUM_BEATS - 1);
            exp_q.push_back(b);
        end
        tick();

        // REQ
        evict_valid = v.hold_valid;
        flip_req    = 1'b0;
        if (v.hold_valid) evict_index = ~v.idx;
        for (int s = 0; s <= v.req_stall; s++) begin
            mem_req_ready = (s == v.req_stall);
            mem_ack       = v.stray_ack && s == 0 && v.req_stall > 0;
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_req_addr, v.exp_addr);
            check("req_no_data", mem_data_valid, 0);
            check("ready_while_busy", evict_ready, 0);
            #1 check("da_index_held", da_index, v.idx);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_ack       = 1'b0;

        // DATA
        beats = 0;
        dcyc  = 0;
        while (beats < NUM_BEATS && dcyc < 64) begin
            mem_data_ready = v.toggle ? (dcyc % 2 == 0) : 1'b1;
            check("data_valid", mem_data_valid, 1);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_beat: got beat 0x%0h, expected none", mem_data);
            end else begin
                check("beat_data", mem_data, exp_q[0].data);
                check("beat_last", mem_data_last, exp_q[0].last);
                if (mem_data_valid && mem_data_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            dcyc++;
            tick();
        end
        mem_data_ready = 1'b0;
        check("beats_done", beats, NUM_BEATS);
        check("queue_empty", exp_q.size(), 0);

        // ACK
        for (int a = 0; a < v.ack_delay; a++) begin
            check("ack_wait_busy", busy, 1);
            check("ack_no_req", mem_req_valid, 0);
            check("ack_no_data", mem_data_valid, 0);
            check("ack_not_ready", evict_ready, 0);
            tick();
        end
        check("ack_busy", busy, 1);
        check("ack_data_idle", mem_data_valid, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack     = 1'b0;
        evict_valid = 1'b0;
        check("ready_after_ack", evict_ready, 1);
        check("idle_after_ack", busy, 0);
        check("occupancy", busy_cyc, v.exp_busy);
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        vecs[0] = '{6'd5,  2'd2, 20'hABCDE, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 32'hABCDE140, 10};
        vecs[1] = '{6'd63, 2'd3, 20'hFFFFF, 0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 32'hFFFFFFC0, 19};
        vecs[2] = '{6'd0,  2'd0, 20'h00000, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h00000000, 15};
        vecs[3] = '{6'd1,  2'd1, 20'h12345, 3, 1'b0, 3, 1'b1, 1'b1, 1'b0, 32'h12345040, 16};
        vecs[4] = '{6'd42, 2'd1, 20'h5A5A5, 2, 1'b1, 1, 1'b0, 1'b1, 1'b0, 32'h5A5A5A80, 20};

        rst_n          = 1'b0;
        evict_valid    = 1'b0;
        evict_index    = '0;
        evict_way      = '0;
        evict_tag      = '0;
        mem_req_ready  = 1'b0;
        mem_data_ready = 1'b0;
        mem_ack        = 1'b0;
        flip_req       = 1'b0;

        #12;
        check("rst_evict_ready", evict_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_data_valid", mem_data_valid, 0);
        check("rst_data_last", mem_data_last, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_req_addr", mem_req_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_evict(vecs[i]);

        // Reset while streaming: drop the line, no beats afterwards.
        evict_index = 6'd7;
        evict_way   = 2'd1;
        evict_tag   = 20'h0F00D;
        evict_valid = 1'b1;
        tick();
        evict_valid   = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_data_ready = 1'b1;
        tick();
        tick();
        check("pre_reset_in_data", mem_data_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_valid", mem_data_valid, 0);
        check("mid_rst_req_valid", mem_req_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_evict_ready", evict_ready, 1);
        check("mid_rst_data_last", mem_data_last, 0);
        check("mid_rst_mem_data", mem_data, 0);
        check("mid_rst_req_addr", mem_req_addr, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_beat", mem_data_valid, 0);
            check("post_rst_idle", busy, 0);
        end
        mem_data_ready = 1'b0;
        exp_q.delete();

        run_evict(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
